// File: rtl/slice_extract_pipe.sv
// slice_extract_pipe
// Registered, back-pressured bit-field extractor. Each accepted IN_W-bit word is
// reduced to the OUT_W-bit field that starts at a programmable offset. The field
// can optionally be bit-reversed. Results queue in a 2-entry FIFO, which gives
// full throughput under valid/ready flow control and leaves no combinational
// path from the input side to the output side.
module slice_extract_pipe #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 4,
  parameter int DEF_OFFSET = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [$clog2(IN_W)-1:0] cfg_offset,
  input  logic                    cfg_rev,
  output logic                    cfg_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [CNT_W-1:0]        beat_cnt
);

  localparam int OFF_W   = $clog2(IN_W);
  localparam int MAX_OFF = IN_W - OUT_W;  // highest offset that keeps the field inside the word

  // Configuration state
  logic [OFF_W-1:0] offset_q, offset_d;
  logic             rev_q, rev_d;
  logic             cfg_err_q, cfg_err_d;

  // Output FIFO: slot0 is always the head, slot1 holds the second word
  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] slot0_q, slot0_d;
  logic [OUT_W-1:0] slot1_q, slot1_d;
  logic [CNT_W-1:0] beat_q, beat_d;

  logic [OUT_W-1:0] field_raw;
  logic [OUT_W-1:0] field;
  logic             push;
  logic             pop;

  // Configuration update with clamping of out-of-range offsets
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    offset_d  = offset_q;
    rev_d     = rev_q;
    cfg_err_d = cfg_err_q;
    if (cfg_we) begin
      rev_d = cfg_rev;
      if (int'(cfg_offset) <= MAX_OFF) begin
        offset_d = cfg_offset;
      end else begin
        offset_d  = OFF_W'(MAX_OFF);
        cfg_err_d = 1'b1;
      end
    end
  end

  // Field extraction uses the registered config, so a same-cycle cfg_we applies to the next word
  always_comb begin
    field_raw = OUT_W'(in_data >> offset_q);
    field     = field_raw;
    if (rev_q) begin
      for (int i = 0; i < OUT_W; i++) begin
        field[i] = field_raw[OUT_W-1-i];
      end
    end
  end

  // Handshake decode. in_ready depends only on registered count and rst, never on out_ready
  always_comb begin
    in_ready  = ~rst & (count_q != 2'd2);
    out_valid = (count_q != 2'd0);
    out_data  = slot0_q;
    cfg_err   = cfg_err_q;
    beat_cnt  = beat_q;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // FIFO next state and beat counter
  always_comb begin
    count_d = count_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    beat_d  = beat_q;
    if (push) begin
      beat_d = beat_q + CNT_W'(1);
    end
    unique case (count_q)
      2'd0: begin
        if (push) begin
          slot0_d = field;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        unique case ({push, pop})
          2'b11: slot0_d = field;  // head leaves and the new word takes its place
          2'b10: begin
            slot1_d = field;
            count_d = 2'd2;
          end
          2'b01: count_d = 2'd0;
          default: ;
        endcase
      end
      2'd2: begin
        if (pop) begin
          slot0_d = slot1_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      offset_q  <= OFF_W'(DEF_OFFSET);
      rev_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      count_q   <= 2'd0;
      // NOTE: the data slots are reset too, because out_data must read 0 after reset; slot1 is reset only for determinism.
      slot0_q   <= '0;
      slot1_q   <= '0;
      beat_q    <= '0;
    end else begin
      offset_q  <= offset_d;
      rev_q     <= rev_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      beat_q    <= beat_d;
    end
  end

endmodule

// File: tb/tb_slice_extract_pipe.sv
// Directed testbench for slice_extract_pipe. Inputs are driven and outputs are
// sampled on the falling edge. A second instance with CNT_W=4 shares all inputs
// and is used to show the beat counter wrapping.
module tb_slice_extract_pipe;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_offset;
  logic        cfg_rev;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        cfg_err, in_ready, out_valid;
  logic [3:0]  out_data;
  logic [15:0] beat_cnt;

  logic        w_cfg_err, w_in_ready, w_out_valid;
  logic [3:0]  w_out_data;
  logic [3:0]  w_beat_cnt;

  int n_checks;
  int n_fail;

  slice_extract_pipe dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_offset(cfg_offset), .cfg_rev(cfg_rev),
    .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .beat_cnt(beat_cnt)
  );

  slice_extract_pipe #(.CNT_W(4)) dut_wrap (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_offset(cfg_offset), .cfg_rev(cfg_rev),
    .cfg_err(w_cfg_err), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .beat_cnt(w_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h00A5;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    n_checks++;
    if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d required 0", beat_cnt); end
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b required 0", cfg_err); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready: got %b required 1", in_ready); end
    in_valid = 1'b1; in_data = 16'h00A5;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b required 1", out_valid); end
    n_checks++;
    if (out_data !== 4'hA) begin n_fail++; $display("FAIL basic_out_data: got %h required a", out_data); end
    n_checks++;
    if (beat_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_beat_cnt: got %0d required 1", beat_cnt); end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b required 0", out_valid); end
  endtask

  task automatic test_cfg_timing();
    @(negedge clk);
    cfg_we = 1'b1; cfg_offset = 4'd0; cfg_rev = 1'b1;
    in_valid = 1'b1; in_data = 16'h0010;  // old cfg (offset 4) gives 1, new cfg would give 0
    @(negedge clk);
    n_checks++;
    if (out_data !== 4'h1) begin n_fail++; $display("FAIL cfg_old_value: got %h required 1", out_data); end
    cfg_we = 1'b0; in_data = 16'h0001;
    @(negedge clk);
    n_checks++;
    if (out_data !== 4'h8) begin n_fail++; $display("FAIL cfg_reversed: got %h required 8", out_data); end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (beat_cnt !== 16'd3) begin n_fail++; $display("FAIL cfg_beat_cnt: got %0d required 3", beat_cnt); end
  endtask

  task automatic test_clamp();
    @(negedge clk);
    cfg_we = 1'b1; cfg_offset = 4'd12; cfg_rev = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL clamp_edge_12: got err %b required 0", cfg_err); end
    cfg_offset = 4'd15;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL clamp_err_set: got %b required 1", cfg_err); end
    cfg_we = 1'b0; in_valid = 1'b1; in_data = 16'hB000;
    @(negedge clk);
    n_checks++;
    if (out_data !== 4'hB) begin n_fail++; $display("FAIL clamp_out_data: got %h required b", out_data); end
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_offset = 4'd4;
    @(negedge clk);
    cfg_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL clamp_err_sticky: got %b required 1", cfg_err); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0010;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one: got %b required 1", in_ready); end
    in_data = 16'h0020;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b required 0", in_ready); end
    n_checks++;
    if (out_data !== 4'h1) begin n_fail++; $display("FAIL bp_head_held: got %h required 1", out_data); end
    in_data = 16'h0030;
    @(negedge clk);
    n_checks++;
    if (beat_cnt !== 16'd6) begin n_fail++; $display("FAIL bp_no_accept: got %0d required 6", beat_cnt); end
    n_checks++;
    if (out_data !== 4'h1) begin n_fail++; $display("FAIL bp_stable: got %h required 1", out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_data !== 4'h2) begin n_fail++; $display("FAIL bp_second: got %h required 2", out_data); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_reopen: got %b required 1", in_ready); end
    @(negedge clk);
    n_checks++;
    if (out_data !== 4'h3) begin n_fail++; $display("FAIL bp_third: got %h required 3", out_data); end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b required 0", out_valid); end
    n_checks++;
    if (beat_cnt !== 16'd7) begin n_fail++; $display("FAIL bp_beat_cnt: got %0d required 7", beat_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = 4'(i - 1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
          n_fail++; $display("FAIL b2b_word_%0d: got v=%b d=%h required v=1 d=%h", i - 1, out_valid, out_data, exp);
        end
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b required 1", i, in_ready); end
      in_valid = 1'b1; in_data = 16'(i) << 4;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_data !== 4'h3) begin n_fail++; $display("FAIL b2b_last: got %h required 3", out_data); end
    n_checks++;
    if (beat_cnt !== 16'd100) begin n_fail++; $display("FAIL b2b_beat_cnt: got %0d required 100", beat_cnt); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    out_ready = 1'b0; cfg_we = 1'b1; cfg_offset = 4'd15; cfg_rev = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b1; in_data = 16'h0010;
    @(negedge clk);
    in_data = 16'h0020;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || cfg_err !== 1'b1) begin
      n_fail++; $display("FAIL mid_prefill: got rdy=%b v=%b err=%b required 0 1 1", in_ready, out_valid, cfg_err);
    end
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b required 0", out_valid); end
    n_checks++;
    if (beat_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_beat_cnt: got %0d required 0", beat_cnt); end
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL mid_cfg_err: got %b required 0", cfg_err); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
    rst = 1'b0; in_valid = 1'b1; in_data = 16'h0050;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h5) begin
      n_fail++; $display("FAIL mid_default_offset: got v=%b d=%h required v=1 d=5", out_valid, out_data);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'(i) << 4;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (w_beat_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_cnt4: got %0d required 0", w_beat_cnt); end
    n_checks++;
    if (beat_cnt !== 16'd16) begin n_fail++; $display("FAIL wrap_cnt16: got %0d required 16", beat_cnt); end
    n_checks++;
    if (w_out_valid !== 1'b1 || w_out_data !== 4'hF) begin
      n_fail++; $display("FAIL wrap_out: got v=%b d=%h required v=1 d=f", w_out_valid, w_out_data);
    end
    n_checks++;
    if (w_cfg_err !== 1'b0 || w_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL wrap_flags: got err=%b rdy=%b required 0 1", w_cfg_err, w_in_ready);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; cfg_we = 1'b0; cfg_offset = '0; cfg_rev = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_basic();
    test_cfg_timing();
    test_clamp();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
